// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg
//   Shared definitions for the convolution sequencer: the FSM state encoding
//   and the index-width helper used to size every counter and index port.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KERN,
    LOAD_IF,
    COMPUTE,
    WRITE,
    SLIDE,
    NEXT_ROW,
    DONE
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/conv_seq_counter.sv
// conv_seq_counter
//   Wrapping up-counter over 0..MAX-1.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     en       : advance by one (wraps to 0 after MAX-1)
//     clr      : synchronous clear, wins over en
//     count    : current value
//     last     : count == MAX-1
module conv_seq_counter
  import conv_seq_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = idx_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    last    = (count_q == W'(MAX - 1));
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Sequences a convolution engine through kernel load, ifmap window load,
//   per-kernel MAC passes for every output position and window sliding.
//   Optional feature macro: CONV_SEQ_ABORT_EN adds abort/aborted.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     start             : begin a frame (accepted only in IDLE with stall low)
//     stall             : freeze state/counters, suppress all strobes
//     abort / aborted   : (CONV_SEQ_ABORT_EN) return to IDLE / 1-cycle ack
//     busy, done        : not-IDLE flag, end-of-frame pulse
//     kern_wr_en, k_row : one-hot filter write enable, row index for loads
//     if_load,row_shift : ifmap row load, shift-up-first qualifier
//     win_shift         : shift window one column right
//     mac_en, acc_clr   : MAC step enable, accumulator clear on first step
//     k_sel, mac_step   : kernel and step index for MAC/write
//     out_wr, out_col, out_row : output memory write and its coordinates
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter  int N_KERNELS = 4,
  parameter  int K_SIZE    = 4,
  parameter  int IMG_W     = 16,
  parameter  int IMG_H     = 16,
  parameter  int STRIDE    = 1,
  localparam int OUT_W     = (IMG_W - K_SIZE) / STRIDE + 1,
  localparam int OUT_H     = (IMG_H - K_SIZE) / STRIDE + 1,
  localparam int KW        = idx_width(N_KERNELS),
  localparam int RW        = idx_width(K_SIZE),
  localparam int CW        = idx_width(OUT_W),
  localparam int HW        = idx_width(OUT_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
`ifdef CONV_SEQ_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [N_KERNELS-1:0] kern_wr_en,
  output logic [RW-1:0]        k_row,
  output logic                 if_load,
  output logic                 row_shift,
  output logic                 win_shift,
  output logic                 mac_en,
  output logic                 acc_clr,
  output logic [KW-1:0]        k_sel,
  output logic [RW-1:0]        mac_step,
  output logic                 out_wr,
  output logic [CW-1:0]        out_col,
  output logic [HW-1:0]        out_row
);

  if (((IMG_W - K_SIZE) % STRIDE) != 0 || ((IMG_H - K_SIZE) % STRIDE) != 0) begin : g_bad_stride
    $error("conv_sequencer: image minus kernel size must be a multiple of STRIDE");
  end

  state_e state_q, state_d;

  logic r_en, kc_en, col_en, orow_en, sc_en, clr_all;
  logic r_last, kc_last, col_last, orow_last, sc_last;
  logic [RW-1:0] r_cnt;
  logic [KW-1:0] kc_cnt;
  logic [CW-1:0] col_cnt;
  logic [HW-1:0] orow_cnt;
  logic [idx_width(STRIDE)-1:0] sc_cnt_unused;

  conv_seq_counter #(.MAX(K_SIZE)) u_r (
    .clk(clk), .rst(rst), .en(r_en), .clr(clr_all), .count(r_cnt), .last(r_last)
  );
  conv_seq_counter #(.MAX(N_KERNELS)) u_kc (
    .clk(clk), .rst(rst), .en(kc_en), .clr(clr_all), .count(kc_cnt), .last(kc_last)
  );
  conv_seq_counter #(.MAX(OUT_W)) u_col (
    .clk(clk), .rst(rst), .en(col_en), .clr(clr_all), .count(col_cnt), .last(col_last)
  );
  conv_seq_counter #(.MAX(OUT_H)) u_orow (
    .clk(clk), .rst(rst), .en(orow_en), .clr(clr_all), .count(orow_cnt), .last(orow_last)
  );
  conv_seq_counter #(.MAX(STRIDE)) u_sc (
    .clk(clk), .rst(rst), .en(sc_en), .clr(clr_all), .count(sc_cnt_unused), .last(sc_last)
  );

  // Next state and counter control.
  always_comb begin
    state_d = state_q;
    r_en    = 1'b0;
    kc_en   = 1'b0;
    col_en  = 1'b0;
    orow_en = 1'b0;
    sc_en   = 1'b0;
    clr_all = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stall) begin
          state_d = LOAD_KERN;
          clr_all = 1'b1;
        end
      end
      LOAD_KERN: begin
        r_en  = 1'b1;
        kc_en = r_last;
        if (r_last && kc_last) state_d = LOAD_IF;
      end
      LOAD_IF: begin
        r_en = 1'b1;
        if (r_last) state_d = COMPUTE;
      end
      COMPUTE: begin
        r_en = 1'b1;
        if (r_last) state_d = WRITE;
      end
      WRITE: begin
        // kc wraps to 0 after the last kernel, ready for the next position.
        kc_en = 1'b1;
        if (!kc_last)        state_d = COMPUTE;
        else if (!col_last)  state_d = SLIDE;
        else if (!orow_last) state_d = NEXT_ROW;
        else                 state_d = DONE;
      end
      SLIDE: begin
        sc_en = 1'b1;
        if (sc_last) begin
          col_en  = 1'b1;
          state_d = COMPUTE;
        end
      end
      NEXT_ROW: begin
        // col is at its last value here, so advancing it wraps it to 0.
        sc_en = 1'b1;
        if (sc_last) begin
          col_en  = 1'b1;
          orow_en = 1'b1;
          state_d = COMPUTE;
        end
      end
      DONE: begin
        clr_all = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stall) begin
      state_d = state_q;
      r_en    = 1'b0;
      kc_en   = 1'b0;
      col_en  = 1'b0;
      orow_en = 1'b0;
      sc_en   = 1'b0;
      clr_all = 1'b0;
    end

`ifdef CONV_SEQ_ABORT_EN
    // abort overrides stall and everything else outside IDLE.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      r_en    = 1'b0;
      kc_en   = 1'b0;
      col_en  = 1'b0;
      orow_en = 1'b0;
      sc_en   = 1'b0;
      clr_all = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CONV_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign aborted_d = abort && (state_q != IDLE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end
  assign aborted = aborted_q;
`endif

  // Output decode: strobes are qualified by !stall, indices are not, so a
  // stalled cycle keeps presenting the same indices.
  logic act;
  always_comb begin
    act        = !stall;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE) && act;
    kern_wr_en = '0;
    k_row      = '0;
    if_load    = 1'b0;
    row_shift  = 1'b0;
    win_shift  = 1'b0;
    mac_en     = 1'b0;
    acc_clr    = 1'b0;
    k_sel      = '0;
    mac_step   = '0;
    out_wr     = 1'b0;
    out_col    = '0;
    out_row    = '0;
    case (state_q)
      LOAD_KERN: begin
        kern_wr_en = act ? (N_KERNELS'(1) << kc_cnt) : '0;
        k_row      = r_cnt;
      end
      LOAD_IF: begin
        if_load = act;
        k_row   = r_cnt;
      end
      COMPUTE: begin
        mac_en   = act;
        acc_clr  = act && (r_cnt == '0);
        k_sel    = kc_cnt;
        mac_step = r_cnt;
      end
      WRITE: begin
        out_wr  = act;
        k_sel   = kc_cnt;
        out_col = col_cnt;
        out_row = orow_cnt;
      end
      SLIDE: win_shift = act;
      NEXT_ROW: begin
        if_load   = act;
        row_shift = act;
        k_row     = RW'(K_SIZE - 1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
//   Scoreboard bench. DUT A: N_KERNELS=2, K_SIZE=2, 3x3 image, STRIDE=1.
//   DUT B: N_KERNELS=1, K_SIZE=2, 6x6 image, STRIDE=2.
//   Stimulus pushes expected out_wr tuples and done cycles; per-DUT monitors
//   pop and compare on each out_wr/done and check strobe rules every cycle.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A
  logic       start_a, stall_a, busy_a, done_a;
  logic [1:0] kern_a;
  logic [0:0] krow_a, ksel_a, step_a, ocol_a, orow_a;
  logic       if_load_a, row_shift_a, win_shift_a, mac_en_a, acc_clr_a, out_wr_a;
  // DUT B
  logic       start_b, stall_b, busy_b, done_b;
  logic [0:0] kern_b, krow_b, ksel_b, step_b;
  logic [1:0] ocol_b, orow_b;
  logic       if_load_b, row_shift_b, win_shift_b, mac_en_b, acc_clr_b, out_wr_b;
`ifdef CONV_SEQ_ABORT_EN
  logic       abort_a, aborted_a, aborted_b;
`endif

  conv_sequencer #(.N_KERNELS(2), .K_SIZE(2), .IMG_W(3), .IMG_H(3), .STRIDE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
`ifdef CONV_SEQ_ABORT_EN
    .abort(abort_a), .aborted(aborted_a),
`endif
    .busy(busy_a), .done(done_a), .kern_wr_en(kern_a), .k_row(krow_a),
    .if_load(if_load_a), .row_shift(row_shift_a), .win_shift(win_shift_a),
    .mac_en(mac_en_a), .acc_clr(acc_clr_a), .k_sel(ksel_a), .mac_step(step_a),
    .out_wr(out_wr_a), .out_col(ocol_a), .out_row(orow_a)
  );

  conv_sequencer #(.N_KERNELS(1), .K_SIZE(2), .IMG_W(6), .IMG_H(6), .STRIDE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
`ifdef CONV_SEQ_ABORT_EN
    .abort(1'b0), .aborted(aborted_b),
`endif
    .busy(busy_b), .done(done_b), .kern_wr_en(kern_b), .k_row(krow_b),
    .if_load(if_load_b), .row_shift(row_shift_b), .win_shift(win_shift_b),
    .mac_en(mac_en_b), .acc_clr(acc_clr_b), .k_sel(ksel_b), .mac_step(step_b),
    .out_wr(out_wr_b), .out_col(ocol_b), .out_row(orow_b)
  );

  int wr_q_a[$];
  int wr_q_b[$];
  int done_q_a[$];
  int done_q_b[$];

  int acc_cnt_a    = 0;
  int kl_a         = 0;
  int il_a         = 0;
  int win_run_b    = 0;
  int win_bursts_b = 0;
  int rs_run_b     = 0;
  int rs_bursts_b  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor A ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy_a) begin
        kl_a = 0;
        il_a = 0;
      end
      if (stall_a && busy_a)
        check("a_stall_quiet", {kern_a, if_load_a, row_shift_a, win_shift_a,
                                mac_en_a, acc_clr_a, out_wr_a, done_a}, 0);
      if (kern_a != 2'b00) begin
        check("a_kern_load", {kern_a, krow_a}, ((1 << (kl_a / 2)) << 1) | (kl_a % 2));
        kl_a++;
      end
      if (if_load_a && !row_shift_a) begin
        check("a_if_row", krow_a, il_a % 2);
        il_a++;
      end
      if (mac_en_a) begin
        check("a_acc_clr_step", acc_clr_a, (step_a == 1'b0));
        if (acc_clr_a) acc_cnt_a++;
      end else if (acc_clr_a) begin
        check("a_acc_clr_stray", acc_clr_a, 0);
      end
      if (out_wr_a) begin
        if (wr_q_a.size() > 0)
          check("a_out_wr", (int'(orow_a) << 16) | (int'(ocol_a) << 8) | int'(ksel_a),
                wr_q_a.pop_front());
        else
          check("a_out_wr_extra", out_wr_a, 0);
      end
      if (done_a) begin
        if (done_q_a.size() > 0) check("a_done_cycle", cyc, done_q_a.pop_front());
        else                     check("a_done_extra", done_a, 0);
      end
    end
  end

  // ---------------- monitor B ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (win_shift_b) begin
        win_run_b++;
      end else if (win_run_b > 0) begin
        check("b_win_burst_len", win_run_b, 2);
        win_bursts_b++;
        win_run_b = 0;
      end
      if (row_shift_b) begin
        check("b_next_row_krow", krow_b, 1);
        rs_run_b++;
      end else if (rs_run_b > 0) begin
        check("b_row_shift_burst_len", rs_run_b, 2);
        rs_bursts_b++;
        rs_run_b = 0;
      end
      if (mac_en_b) check("b_acc_clr_step", acc_clr_b, (step_b == 1'b0));
      if (out_wr_b) begin
        if (wr_q_b.size() > 0)
          check("b_out_wr", (int'(orow_b) << 16) | (int'(ocol_b) << 8) | int'(ksel_b),
                wr_q_b.pop_front());
        else
          check("b_out_wr_extra", out_wr_b, 0);
      end
      if (done_b) begin
        if (done_q_b.size() > 0) check("b_done_cycle", cyc, done_q_b.pop_front());
        else                     check("b_done_extra", done_b, 0);
      end
    end
  end

  // Push the 8 expected writes and the done cycle, then pulse start.
  // Frame length for A: 2*2 + 2 + 2*2*2*3 + 2*1*1 + 1*1 + 1 = 34.
  task automatic run_a(input int extra);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 2; k++)
          wr_q_a.push_back((r << 16) | (c << 8) | k);
    done_q_a.push_back(cyc + 34 + extra);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Frame length for B: 1*2 + 2 + 9*1*3 + 3*2*2 + 2*2 + 1 = 48.
  task automatic run_b();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        wr_q_b.push_back((r << 16) | (c << 8));
    done_q_b.push_back(cyc + 48);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    for (int i = 0; i < 200 && busy_a; i++) tick();
    check(name, busy_a, 0);
    tick();
  endtask

  task automatic wait_idle_b(input string name);
    for (int i = 0; i < 200 && busy_b; i++) tick();
    check(name, busy_b, 0);
    tick();
  endtask

  task automatic frame_end_checks_a(input int base);
    check("a_acc_clr_count", acc_cnt_a - base, 8);
    check("a_wr_drained", wr_q_a.size(), 0);
    check("a_done_drained", done_q_a.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  found;
    rst     = 1'b1;
    start_a = 1'b0; stall_a = 1'b0;
    start_b = 1'b0; stall_b = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
    abort_a = 1'b0;
`endif
    #1;
    check("rst_busy_a", busy_a, 0);
    check("rst_strobes_a", {kern_a, if_load_a, row_shift_a, win_shift_a, mac_en_a,
                            acc_clr_a, out_wr_a, done_a}, 0);
    check("rst_idx_a", {krow_a, ksel_a, step_a, ocol_a, orow_a}, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_idx_b", {ocol_b, orow_b, krow_b}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: basic frame on A
    base = acc_cnt_a;
    run_a(0);
    wait_idle_a("t1_timeout");
    frame_end_checks_a(base);

    // 2: three stalled cycles at mac_step=1
    base = acc_cnt_a;
    run_a(3);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mac_en_a && step_a == 1'b1) found = 1'b1;
      else tick();
    end
    check("t2_reach_mac1", found, 1);
    stall_a = 1'b1;
    tick();
    check("t2_stall_hold_step", step_a, 1);
    check("t2_stall_busy", busy_a, 1);
    tick(); tick();
    stall_a = 1'b0;
    wait_idle_a("t2_timeout");
    frame_end_checks_a(base);

    // 3: STRIDE=2 frame on B
    base = win_bursts_b;
    run_b();
    wait_idle_b("t3_timeout");
    check("t3_win_bursts", win_bursts_b - base, 6);
    check("t3_row_shift_bursts", rs_bursts_b, 2);
    check("t3_wr_drained", wr_q_b.size(), 0);
    check("t3_done_drained", done_q_b.size(), 0);

    // 4: asynchronous reset in LOAD_KERN, then a clean replay
    run_a(0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t4_async_busy", busy_a, 0);
    check("t4_async_kern", kern_a, 0);
    check("t4_async_krow", krow_a, 0);
    wr_q_a.delete();
    done_q_a.delete();
    tick();
    rst = 1'b0;
    tick();
    base = acc_cnt_a;
    run_a(0);
    wait_idle_a("t4_timeout");
    frame_end_checks_a(base);

    // 5: start while busy and in the done cycle are ignored
    base = acc_cnt_a;
    run_a(0);
    repeat (5) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (done_a) found = 1'b1;
      else tick();
    end
    check("t5_reach_done", found, 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t5_idle_after_done", busy_a, 0);
    tick();
    check("t5_still_idle", busy_a, 0);
    frame_end_checks_a(base);

`ifdef CONV_SEQ_ABORT_EN
    // 6: abort during SLIDE, then a full frame
    run_a(0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (win_shift_a) found = 1'b1;
      else tick();
    end
    check("t6_reach_slide", found, 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t6_aborted_pulse", aborted_a, 1);
    check("t6_abort_idle", busy_a, 0);
    wr_q_a.delete();
    done_q_a.delete();
    tick();
    check("t6_aborted_one_cycle", aborted_a, 0);
    repeat (3) tick();
    base = acc_cnt_a;
    run_a(0);
    wait_idle_a("t6_timeout");
    frame_end_checks_a(base);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
